// File: rtl/pulse_indicator_pkg.sv
// Shared types and board defaults for the event-to-LED flash indicator.
// State encodings are fixed so that debug probes read the same codes on every build.
package pulse_indicator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } pind_state_t;

   // 50 MHz board: 100 ms flash, 50 ms minimum dark gap.
   localparam int DEFAULT_ON_CYCLES  = 5_000_000;
   localparam int DEFAULT_OFF_CYCLES = 2_500_000;
   localparam int DEFAULT_PEND_MAX   = 7;

   // One shared timer covers both phases, so it is sized for the longer one.
   function automatic int timer_width(input int on_c, input int off_c);
      int longest;
      int w;
      longest = (on_c > off_c) ? on_c : off_c;
      w = $clog2(longest);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int count_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter shared by the ON and OFF phases of the indicator FSM.
// A load always wins over the free-running decrement; the count parks at zero.
module pulse_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/pulse_indicator.sv
// Turns single-cycle event strobes into visible LED flashes with a guaranteed dark gap.
// Events arriving mid-flash are queued up to PEND_MAX and replayed; drops set a sticky flag.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | LED dark, nothing queued, waiting for an event
//   ST_ON    | LED lit, timer counting down the ON time
//   ST_OFF   | LED dark, timer counting down the gap; replay or accept at end
module pulse_indicator
   import pulse_indicator_pkg::*;
#(
   parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
   parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
   parameter int PEND_MAX   = DEFAULT_PEND_MAX,
   localparam int PEND_W    = count_width(PEND_MAX)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pulse_in,
   input  logic              clr_overflow,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam int TMR_W = timer_width(ON_CYCLES, OFF_CYCLES);
   localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
   localparam logic [TMR_W-1:0]  OFF_LOAD = TMR_W'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_TOP = PEND_W'(PEND_MAX);

   pind_state_t       state;
   pind_state_t       state_nxt;
   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_value;
   logic              tmr_zero;
   logic              take_direct;
   logic              dequeue;
   logic              enqueue;
   logic              drop;
   logic [PEND_W-1:0] pending_nxt;
   logic              overflow_nxt;

   pulse_timer #(
      .WIDTH (TMR_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_value (tmr_value),
      .zero       (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tmr_load    = 1'b0;
      tmr_value   = ON_LOAD;
      take_direct = 1'b0;
      dequeue     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (pulse_in) begin
               state_nxt   = ST_ON;
               tmr_load    = 1'b1;
               take_direct = 1'b1;
            end
         end
         ST_ON: begin
            if (tmr_zero) begin
               state_nxt = ST_OFF;
               tmr_load  = 1'b1;
               tmr_value = OFF_LOAD;
            end
         end
         ST_OFF: begin
            if (tmr_zero) begin
               // Queued events are older than a fresh strobe, so they go first.
               if (pending != '0) begin
                  state_nxt = ST_ON;
                  tmr_load  = 1'b1;
                  dequeue   = 1'b1;
               end else if (pulse_in) begin
                  state_nxt   = ST_ON;
                  tmr_load    = 1'b1;
                  take_direct = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      enqueue     = pulse_in && !take_direct;
      pending_nxt = pending;
      drop        = 1'b0;
      unique case ({enqueue, dequeue})
         2'b10: begin
            if (pending == PEND_TOP) begin
               drop = 1'b1;
            end else begin
               pending_nxt = pending + 1'b1;
            end
         end
         2'b01:   pending_nxt = pending - 1'b1;
         default: pending_nxt = pending;
      endcase

      overflow_nxt = overflow;
      if (drop) begin
         overflow_nxt = 1'b1;
      end else if (clr_overflow) begin
         overflow_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_out  <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         led_out  <= (state_nxt == ST_ON);
         busy     <= (state_nxt != ST_IDLE);
         pending  <= pending_nxt;
         overflow <= overflow_nxt;
      end
   end

endmodule

// File: tb/tb_pulse_indicator.sv
// Bench for pulse_indicator: directed scenarios plus random strobes, checked every
// cycle against a schedule-based model (flash start times and a queue count).
module tb_pulse_indicator;

   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int PM  = 2;
   localparam int PW  = $clog2(PM + 1);

   logic          clk;
   logic          rst_n;
   logic          pulse_in;
   logic          clr_overflow;
   logic          led_out;
   logic          busy;
   logic [PW-1:0] pending;
   logic          overflow;

   int n_checks;
   int n_fail;

   // Model: a flash occupies ON+OFF edges from its start edge; the edge at
   // start+ON+OFF is where the next flash may begin.
   bit m_active;
   int m_start;
   int m_pend;
   bit m_ovf;
   int cyc;

   pulse_indicator #(
      .ON_CYCLES  (ON),
      .OFF_CYCLES (OFF),
      .PEND_MAX   (PM)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pulse_in     (pulse_in),
      .clr_overflow (clr_overflow),
      .led_out      (led_out),
      .busy         (busy),
      .pending      (pending),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_start  = 0;
      m_pend   = 0;
      m_ovf    = 1'b0;
   endtask

   task automatic model_edge(input bit p, input bit c);
      bit dropped;
      dropped = 1'b0;
      if (!m_active) begin
         if (p) begin
            m_active = 1'b1;
            m_start  = cyc;
         end
      end else if (cyc == m_start + ON + OFF) begin
         if (m_pend > 0) begin
            m_start = cyc;
            m_pend  = m_pend - 1 + (p ? 1 : 0);
         end else if (p) begin
            m_start = cyc;
         end else begin
            m_active = 1'b0;
         end
      end else if (p) begin
         if (m_pend < PM) m_pend++;
         else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
   endtask

   task automatic check_all(input string tag);
      bit exp_led;
      exp_led = m_active && ((cyc - m_start) < ON);
      check_eq({tag, ".led"},      32'(led_out),  32'(exp_led));
      check_eq({tag, ".busy"},     32'(busy),     32'(m_active));
      check_eq({tag, ".pending"},  32'(pending),  m_pend);
      check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   // Entered at a falling edge; drives inputs, takes one rising edge, checks at the next fall.
   task automatic step(input bit p, input bit c, input string tag);
      pulse_in     = p;
      clr_overflow = c;
      @(posedge clk);
      model_edge(p, c);
      @(negedge clk);
      check_all(tag);
      cyc++;
   endtask

   task automatic idle_run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 64 && (m_active || m_pend != 0); i++) step(1'b0, 1'b0, tag);
      step(1'b0, 1'b1, tag);
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      cyc          = 0;
      rst_n        = 1'b0;
      pulse_in     = 1'b0;
      clr_overflow = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;

      // Single flash.
      step(1'b1, 1'b0, "single");
      idle_run(7, "single");

      // Three back-to-back events queue and replay.
      step(1'b1, 1'b0, "queue3");
      step(1'b1, 1'b0, "queue3");
      step(1'b1, 1'b0, "queue3");
      drain("queue3");

      // Fourth event dropped, overflow cleared later.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "drop");
      idle_run(16, "drop");
      step(1'b0, 1'b1, "drop_clr");
      drain("drop");

      // Drop in the same cycle as a clear keeps the flag set.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "drop_vs_clr");
      step(1'b1, 1'b1, "drop_vs_clr");
      step(1'b0, 1'b0, "drop_vs_clr");
      drain("drop_vs_clr");

      // Event on the last OFF edge starts the next flash directly.
      step(1'b1, 1'b0, "last_off");
      idle_run(4, "last_off");
      step(1'b1, 1'b0, "last_off");
      drain("last_off");

      // Event coinciding with a queued flash start.
      step(1'b1, 1'b0, "coincide");
      step(1'b1, 1'b0, "coincide");
      idle_run(3, "coincide");
      step(1'b1, 1'b0, "coincide");
      drain("coincide");

      // Asynchronous reset mid-flash with a full queue and overflow set.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "async_pre");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      pulse_in = 1'b0;
      rst_n    = 1'b1;
      step(1'b1, 1'b0, "post_rst");
      idle_run(6, "post_rst");

      // Random strobes and clears.
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 6), "random");
      end
      drain("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
